// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: captures RGB565 camera bytes into a frame buffer as
// RGB444 pixels, framed by the camera's vsync/href.
//   clk, rst_n          pixel clock, async active-low reset
//   cfg_done            sensor configured (level); low forces IDLE
//   vsync, href         camera frame sync (high = blanking), row valid
//   ca_data[7:0]        camera byte, high byte of each pixel first
//   snap_req, run_req   freeze after next complete frame / resume
//   f_data, f_addr, f_en  frame-buffer write port (one pulse per pixel)
//   frame_done          one-cycle pulse at the end of a captured frame
//   busy, frozen        in WAIT_VS/CAPTURE, in HOLD
//   ovf, row_err        per-frame sticky: pixel dropped, bad row length
// Optional feature: define CAP_SNAPSHOT_EN to enable snap_req/run_req and HOLD.
module frame_capture_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_done,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        ca_data,
  input  logic              snap_req,
  input  logic              run_req,
  output logic [11:0]       f_data,
  output logic [ADDR_W-1:0] f_addr,
  output logic              f_en,
  output logic              frame_done,
  output logic              busy,
  output logic              frozen,
  output logic              ovf,
  output logic              row_err
);

  localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CNT_W = ADDR_W + 1;
  // Room for H_ACTIVE+1 so an over-long row never wraps back to H_ACTIVE.
  localparam int unsigned ROW_W = $clog2(H_ACTIVE + 2);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, HOLD} state_e;

  state_e            state_q, state_d;
  logic              vsync_q, href_q;
  logic              phase_q, phase_d;
  logic [6:0]        hi_q, hi_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [11:0]       f_data_q, f_data_d;
  logic [ADDR_W-1:0] f_addr_q, f_addr_d;
  logic              f_en_q, f_en_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              row_err_q, row_err_d;
  logic              vs_fall_c, vs_rise_c, href_fall_c;

`ifdef CAP_SNAPSHOT_EN
  logic snap_pend_q, snap_pend_d;
  logic frozen_q, frozen_d;
`else
  logic unused_req_c;
  assign unused_req_c = snap_req ^ run_req;
`endif

  // Edges are taken against the registered copies of the camera syncs.
  assign vs_fall_c   = vsync_q & ~vsync;
  assign vs_rise_c   = ~vsync_q & vsync;
  assign href_fall_c = href_q & ~href;

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    pix_cnt_d    = pix_cnt_q;
    row_cnt_d    = row_cnt_q;
    f_data_d     = f_data_q;
    f_addr_d     = f_addr_q;
    f_en_d       = 1'b0;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q;
    row_err_d    = row_err_q;
`ifdef CAP_SNAPSHOT_EN
    snap_pend_d  = snap_pend_q;
    if (snap_req && !run_req) snap_pend_d = 1'b1;
`endif
    if (!cfg_done) begin
      state_d = IDLE;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_VS;
        WAIT_VS: begin
          if (vs_fall_c) begin
            state_d   = CAPTURE;
            f_addr_d  = '0;
            pix_cnt_d = '0;
            row_cnt_d = '0;
            phase_d   = 1'b0;
            ovf_d     = 1'b0;
            row_err_d = 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise_c) begin
            // End of frame; a half-received pixel is dropped.
            frame_done_d = 1'b1;
            phase_d      = 1'b0;
            state_d      = WAIT_VS;
`ifdef CAP_SNAPSHOT_EN
            if (snap_pend_q) begin
              state_d     = HOLD;
              snap_pend_d = 1'b0;
            end
`endif
          end else begin
            if (href) begin
              phase_d = ~phase_q;
              if (!phase_q) begin
                hi_d = {ca_data[7:4], ca_data[2:0]};
              end else begin
                if (row_cnt_q != ROW_W'(H_ACTIVE + 1)) row_cnt_d = row_cnt_q + 1'b1;
                // f_addr keeps the last written address, so it saturates.
                if (pix_cnt_q < CNT_W'(TOTAL)) begin
                  f_data_d  = {hi_q, ca_data[7], ca_data[4:1]};
                  f_addr_d  = pix_cnt_q[ADDR_W-1:0];
                  f_en_d    = 1'b1;
                  pix_cnt_d = pix_cnt_q + 1'b1;
                end else begin
                  ovf_d = 1'b1;
                end
              end
            end else begin
              phase_d = 1'b0;
            end
            if (href_fall_c) begin
              if (row_cnt_q != ROW_W'(H_ACTIVE)) row_err_d = 1'b1;
              row_cnt_d = '0;
            end
          end
        end
`ifdef CAP_SNAPSHOT_EN
        HOLD: if (run_req) state_d = WAIT_VS;
`endif
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == WAIT_VS) || (state_d == CAPTURE);
`ifdef CAP_SNAPSHOT_EN
    frozen_d = (state_d == HOLD);
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      pix_cnt_q    <= '0;
      row_cnt_q    <= '0;
      f_data_q     <= '0;
      f_addr_q     <= '0;
      f_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      row_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      href_q       <= href;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      pix_cnt_q    <= pix_cnt_d;
      row_cnt_q    <= row_cnt_d;
      f_data_q     <= f_data_d;
      f_addr_q     <= f_addr_d;
      f_en_q       <= f_en_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      row_err_q    <= row_err_d;
    end
  end

`ifdef CAP_SNAPSHOT_EN
  // Snapshot request flag and frozen indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_pend_q <= 1'b0;
      frozen_q    <= 1'b0;
    end else begin
      snap_pend_q <= snap_pend_d;
      frozen_q    <= frozen_d;
    end
  end
  assign frozen = frozen_q;
`else
  assign frozen = 1'b0;
`endif

  assign f_data     = f_data_q;
  assign f_addr     = f_addr_q;
  assign f_en       = f_en_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign row_err    = row_err_q;

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per active row.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-buffer address width.
REQ-004 clk  in  1  camera pixel clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_done  in  1  sensor register configuration complete; level.
REQ-007 vsync  in  1  camera frame sync; high = vertical blanking.
REQ-008 href  in  1  camera row-valid; high = active bytes.
REQ-009 ca_data  in  8  camera byte, RGB565, high byte first.
REQ-010 snap_req  in  1  one-cycle pulse: freeze after next complete frame.
REQ-011 run_req  in  1  one-cycle pulse: leave freeze, resume capture.
REQ-012 f_data  out  12  RGB444 pixel to the RAM write port.
REQ-013 f_addr  out  ADDR_W  RAM write address.
REQ-014 f_en  out  1  RAM write enable, one cycle per pixel.
REQ-015 frame_done  out  1  one-cycle pulse at end of a captured frame.
REQ-016 busy  out  1  high in WAIT_VS or CAPTURE.
REQ-017 frozen  out  1  high in HOLD.
REQ-018 ovf  out  1  sticky per frame: pixel beyond H_ACTIVE*V_ACTIVE-1 dropped.
REQ-019 row_err  out  1  sticky per frame: a row ended with pixel count not equal to H_ACTIVE.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_VS, CAPTURE, HOLD.
REQ-021 IDLE->WAIT_VS when cfg_done=1; any state->IDLE when cfg_done=0, with no frame_done.
REQ-022 vsync SHALL be registered once; edges are detected against the registered copy.
REQ-023 WAIT_VS->CAPTURE on vsync falling edge; entry clears f_addr, byte phase, row pixel count, ovf and row_err.
REQ-024 In CAPTURE, byte phase SHALL toggle on every cycle with href=1 and reset to 0 on any cycle with href=0.
REQ-025 Phase 0 byte latched as hi; on the phase 1 byte lo, f_data SHALL be {hi[7:4], hi[2:0], lo[7], lo[4:1]}, with f_en=1 on the next cycle (latency 1).
REQ-026 f_addr SHALL hold the address of the current write and increment by 1 after each f_en; at H_ACTIVE*V_ACTIVE-1 it saturates, further pixels raise no f_en and set ovf.
REQ-027 Row pixel count SHALL increment per pixel; on href falling edge, a count not equal to H_ACTIVE sets row_err; the count then clears.
REQ-028 CAPTURE->WAIT_VS on vsync rising edge, with frame_done=1 for exactly one cycle.
REQ-029 A byte pending in phase 1 when vsync rises SHALL be discarded.
REQ-030 ovf and row_err SHALL hold until the next CAPTURE entry.
REQ-031 f_en SHALL be 0 outside CAPTURE.

Reset
REQ-032 rst_n=0 SHALL force state IDLE; f_data, f_addr, f_en, frame_done, busy, frozen, ovf and row_err all 0; hi, phase, counters and the snap flag cleared; takes effect immediately and mid-frame.

Configuration
REQ-033 Macro CAP_SNAPSHOT_EN defined: snap_req sets a pending flag; the next frame_done moves the FSM to HOLD instead of WAIT_VS, and the flag clears.
REQ-034 With CAP_SNAPSHOT_EN: in HOLD, frozen=1 and f_en=0; run_req moves HOLD->WAIT_VS; snap_req and run_req in the same cycle give run_req priority.
REQ-035 Without CAP_SNAPSHOT_EN: snap_req and run_req are ignored, frozen is tied 0, and HOLD is unreachable.

Verification
REQ-036 Reset, cfg_done=1, vsync falls, 2 rows of 640 pixels at H_ACTIVE=640/V_ACTIVE=2, vsync rises -> 1280 f_en pulses, f_addr 0..1279, one frame_done, ovf=0, row_err=0.
REQ-037 Byte pair 0xF8,0x1F -> f_data=0xF0F; pair 0x07,0xE0 -> f_data=0x0F0; f_en on the cycle after the second byte.
REQ-038 Row of 641 pixels at V_ACTIVE=1 -> f_addr saturates at 639, pixel 641 not written, ovf=1, row_err=1; both clear on the next vsync falling edge.
REQ-039 cfg_done dropped after 100 pixels -> state IDLE, busy=0, no frame_done; rst_n pulsed mid-row -> all outputs 0 asynchronously.
REQ-040 With CAP_SNAPSHOT_EN: snap_req mid-frame -> frame_done, then frozen=1 and no f_en across two further frames; run_req -> busy=1, capture resumes at the next vsync fall with f_addr=0.
REQ-041 Without CAP_SNAPSHOT_EN: same stimulus as REQ-040 -> frozen=0, every frame captured.
